// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - FSM state encoding (3-bit localparams, legacy-compatible)
//   - FRAME_BITS: data bits per frame
//   - DEFAULT_CLKS_PER_BIT: default bit period in clock cycles
//   - parity_of(): frame parity helper
package uart_pkg;

    localparam int FRAME_BITS           = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_of(input logic [FRAME_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a requester and the UART transmitter.
//   tx_data  : byte to send (requester -> transmitter)
//   tx_valid : requester has a byte on tx_data
//   tx_ready : transmitter can accept a byte this cycle
// Modports: master = requester side, slave = transmitter side.
interface uart_tx_if;
    import uart_pkg::*;

    logic [FRAME_BITS-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter.
//   clk, reset : clock, asynchronous active-high reset
//   restart    : hold the counter at 0 (start of a new bit sequence)
//   bit_end    : one-cycle pulse in the last cycle of each bit period
// The counter wraps to 0 on its own at CLKS_PER_BIT-1, so consecutive
// bits need no explicit restart.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    // At least one bit wide so CLKS_PER_BIT=1 still has a legal counter.
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign bit_end = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : byte handshake (uart_tx_if.slave: tx_data, tx_valid, tx_ready)
//   tx         : registered serial line, idles high
//   busy       : a frame is in progress
//   tx_done    : one-cycle pulse in the final cycle of the last stop bit
// Frame: start(0), 8 data bits LSB first, optional parity, STOP_BITS stop(1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BITS - 1);

    logic [2:0]            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [2:0]            bit_idx;
    logic                  stop_cnt;
    logic                  par_bit;
    logic                  bit_end;
    logic                  accept;
    logic                  stop_last;

    // Counter is held at 0 while idle so START always gets a full bit period.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (state == ST_IDLE),
        .bit_end (bit_end)
    );

    assign bus.tx_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign accept       = bus.tx_valid && bus.tx_ready;
    assign stop_last    = (STOP_BITS == 1) || stop_cnt;
    assign tx_done      = (state == ST_STOP) && bit_end && stop_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        shreg   <= bus.tx_data;
                        par_bit <= parity_of(bus.tx_data, PARITY_ODD != 0);
                        state   <= ST_START;
                        tx      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state    <= ST_STOP;
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state    <= ST_STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_last)
                            state <= ST_IDLE;
                        else
                            stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
